uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Consumes the received byte stream popped from the UART receive FIFO and turns ASCII commands into single-cycle control pulses and a validated time-set strobe for the watch/stopwatch datapath. Single-character commands map directly to button-equivalent pulses. A multi-byte set command "S" + HHMMSS + CR/LF loads a time value. The block sits directly downstream of the UART/FIFO wrapper: its byte input is that wrapper's FIFO read data, qualified by the wrapper's read-enable.

## Interface
- TIMEOUT_S, 3: whole seconds (tick_1s pulses) an incomplete set command may stay idle before it is aborted; legal range 1–15.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only in a cycle where rx_valid=1.
- rx_valid  in  1  one-cycle byte strobe, the FIFO read-enable; one byte is consumed per high cycle, and back-to-back high cycles are legal.
- tick_1s  in  1  one-cycle 1 Hz tick.
- o_run  out  1  run/stop toggle pulse.
- o_clear  out  1  clear pulse.
- o_mode  out  1  mode-change pulse.
- o_set_valid  out  1  pulse; o_set_hour/min/sec are valid in this cycle.
- o_set_hour  out  5  0–23.
- o_set_min  out  6  0–59.
- o_set_sec  out  6  0–59.
- o_err  out  1  pulse on malformed, out-of-range or timed-out command.
- o_busy  out  1  high while a set command is in progress, meaning state is not IDLE.

## Operation
- FSM states: IDLE, DIGITS, EOL.
- IDLE:
  - 'R' → o_run.
  - 'C' → o_clear.
  - 'M' → o_mode.
  - 'S' → clear the digit index and go to DIGITS.
  - Space, CR (0x0D) and LF (0x0A) are ignored.
  - Any other byte → o_err.
- DIGITS:
  - An ASCII '0'–'9' is stored at digit index 0..5. The index increments, and after the 6th digit the FSM goes to EOL.
  - Any other byte, including CR/LF → o_err, go to IDLE.
- EOL:
  - CR or LF → range check.
  - If HH≤23, MM≤59 and SS≤59 → o_set_valid with the values. Otherwise o_err.
  - Either way, go to IDLE.
  - Any other byte → o_err, go to IDLE.
- Arithmetic:
  - Each field = tens×10 + ones, computed from 4-bit digit values (byte − 0x30).
  - Hour uses a 7-bit intermediate, min/sec use 7 bits; each is checked before truncation to the output width.
  - Out-of-range fields never reach the outputs.
- Timeout:
  - A 4-bit counter clears on entry to DIGITS and on every accepted byte, and increments on tick_1s while not IDLE.
  - When it reaches TIMEOUT_S → o_err, go to IDLE, and discard the partial digits.
- Simultaneous events: if rx_valid and the timeout-expiring tick_1s land in the same cycle, the byte is processed and the counter clears, so the timeout does not fire.
- Only one pulse output is high in any cycle.

## Timing
- All outputs are registered. A pulse is high exactly one cycle, in the cycle after the rx_valid cycle that caused it.
- o_set_hour/min/sec update in the same cycle as o_set_valid and hold their value until the next o_set_valid.
- o_busy reflects the registered state: it rises the cycle after 'S' is accepted and falls the cycle after the terminating or aborting byte.
- Throughput: one byte per cycle, no stalls, no backpressure.
- Reset values: state IDLE, all pulse outputs 0, o_busy 0, o_set_* 0, timeout counter 0.
- Reset mid-command: the partial command is discarded with no o_err, and the block returns to IDLE in the next cycle.

## Configuration
- CMD_CASE_INSENSITIVE_EN:
  - Defined: in IDLE, 'r', 'c', 'm' and 's' are accepted as equivalent to 'R', 'C', 'M' and 'S'.
  - Undefined: lowercase letters are treated as any other byte and produce o_err.
- Digit handling and terminators are unaffected by the macro.

## Test plan
- Bytes 'R','C','M' on three consecutive cycles → o_run, o_clear, o_mode each pulse once on the following three cycles; o_err stays 0.
- "S235959\r" back-to-back → one cycle after '\r', o_set_valid=1 with hour=23, min=59, sec=59. o_busy is high from the cycle after 'S' through the cycle of '\r'.
- "S240000\n" → o_err pulses; o_set_valid is never asserted; o_set_* retain their prior values.
- "S12" then no bytes, TIMEOUT_S=3 → o_err on the cycle after the 3rd tick_1s. A 4th byte arriving in the same cycle as that 3rd tick is processed instead and no timeout fires.
- "S12a" → o_err on the cycle after 'a', state returns to IDLE. A following "C" produces o_clear.
- With CMD_CASE_INSENSITIVE_EN defined, 'r' → o_run; without it, 'r' → o_err. Asserting rst after "S1234" → no pulses, o_busy=0 the next cycle.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// Byte-in / command-pulse-out bundle between the UART FIFO wrapper and the command decoder.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       o_run;
  logic       o_clear;
  logic       o_mode;
  logic       o_set_valid;
  logic [4:0] o_set_hour;
  logic [5:0] o_set_min;
  logic [5:0] o_set_sec;
  logic       o_err;
  logic       o_busy;

  modport master (
    output rx_data, rx_valid,
    input  o_run, o_clear, o_mode, o_set_valid, o_set_hour, o_set_min, o_set_sec, o_err, o_busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output o_run, o_clear, o_mode, o_set_valid, o_set_hour, o_set_min, o_set_sec, o_err, o_busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: R/C/M pulses and "S"+HHMMSS+CR/LF time-set with idle timeout.
// Define CMD_CASE_INSENSITIVE_EN to also accept r/c/m/s in IDLE.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_S = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1s,
  uart_cmd_decoder_if.slave  bus
);

  typedef enum logic [1:0] { IDLE, DIGITS, EOL } state_t;

  typedef struct packed {
    logic run;
    logic clear;
    logic mode;
    logic set_valid;
    logic err;
  } pulse_t;

  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_M  = 8'h4D;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [4:0] TMO   = 5'(TIMEOUT_S);

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic [3:0]      tmo_q, tmo_d;
  pulse_t          pls_q, pls_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            busy_q, busy_d;

  logic [7:0] cmd;
  logic       is_dig;
  logic       is_eol;
  logic [6:0] hh, mm, ss;

  always_comb begin
`ifdef CMD_CASE_INSENSITIVE_EN
    cmd = (bus.rx_data inside {8'h72, 8'h63, 8'h6D, 8'h73}) ? (bus.rx_data & 8'hDF) : bus.rx_data;
`else
    cmd = bus.rx_data;
`endif
  end

  assign is_dig = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign is_eol = (bus.rx_data == CH_CR) || (bus.rx_data == CH_LF);

  // 7-bit intermediates so out-of-range fields are caught before truncation
  assign hh = 7'(dig_q[0]) * 7'd10 + 7'(dig_q[1]);
  assign mm = 7'(dig_q[2]) * 7'd10 + 7'(dig_q[3]);
  assign ss = 7'(dig_q[4]) * 7'd10 + 7'(dig_q[5]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dig_d   = dig_q;
    tmo_d   = tmo_q;
    pls_d   = '0;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (bus.rx_valid) begin
          case (cmd)
            CH_R: pls_d.run   = 1'b1;
            CH_C: pls_d.clear = 1'b1;
            CH_M: pls_d.mode  = 1'b1;
            CH_S: begin
              idx_d   = '0;
              state_d = DIGITS;
            end
            CH_SP, CH_CR, CH_LF: ;
            default: pls_d.err = 1'b1;
          endcase
        end
      end
      DIGITS, EOL: begin
        if (bus.rx_valid) begin
          // any byte consumed here restarts the idle timer, even one coinciding with a tick
          tmo_d = '0;
          if (state_q == DIGITS) begin
            if (is_dig) begin
              dig_d[idx_q] = bus.rx_data[3:0];
              idx_d        = idx_q + 3'd1;
              if (idx_q == 3'd5) state_d = EOL;
            end else begin
              pls_d.err = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            state_d = IDLE;
            if (is_eol && hh <= 7'd23 && mm <= 7'd59 && ss <= 7'd59) begin
              pls_d.set_valid = 1'b1;
              hour_d          = hh[4:0];
              min_d           = mm[5:0];
              sec_d           = ss[5:0];
            end else begin
              pls_d.err = 1'b1;
            end
          end
        end else if (tick_1s) begin
          if ({1'b0, tmo_q} + 5'd1 == TMO) begin
            pls_d.err = 1'b1;
            state_d   = IDLE;
            tmo_d     = '0;
            idx_d     = '0;
            dig_d     = '0;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dig_q   <= '0;
      tmo_q   <= '0;
      pls_q   <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      tmo_q   <= tmo_d;
      pls_q   <= pls_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_run       = pls_q.run;
  assign bus.o_clear     = pls_q.clear;
  assign bus.o_mode      = pls_q.mode;
  assign bus.o_set_valid = pls_q.set_valid;
  assign bus.o_err       = pls_q.err;
  assign bus.o_set_hour  = hour_q;
  assign bus.o_set_min   = min_q;
  assign bus.o_set_sec   = sec_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: string-level command model, decoupled pulse monitor.
module tb_uart_cmd_decoder;
  localparam int TO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_1s = 1'b0;

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(.TIMEOUT_S(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_1s (tick_1s),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // pulse vector order: {run, clear, mode, set_valid, err}
  typedef struct { int cyc; logic [4:0] pv; int h; int m; int s; } ev_t;
  typedef struct { bit busy; int h; int m; int s; } st_t;

  ev_t evq[$];
  st_t stq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  // reference state: command text collected so far, seconds idle, last loaded time
  bit         in_cmd = 0;
  logic [7:0] digs[$];
  int         secs = 0;
  int         eh = 0, em = 0, es = 0;

  function automatic int dv(logic [7:0] c);
    return int'(c) - 48;
  endfunction

  task automatic model(bit r, bit v, logic [7:0] d, bit t);
    logic [4:0] pv;
    logic [7:0] c;
    int h, m, s;
    pv = '0;
    if (r) begin
      in_cmd = 0; secs = 0; digs.delete(); eh = 0; em = 0; es = 0;
    end else if (v) begin
      if (!in_cmd) begin
        c = d;
`ifdef CMD_CASE_INSENSITIVE_EN
        if (c == "r" || c == "c" || c == "m" || c == "s") c = c - 8'd32;
`endif
        if      (c == "R") pv = 5'b10000;
        else if (c == "C") pv = 5'b01000;
        else if (c == "M") pv = 5'b00100;
        else if (c == "S") begin in_cmd = 1; secs = 0; digs.delete(); end
        else if (c == " " || c == 8'h0D || c == 8'h0A) pv = '0;
        else pv = 5'b00001;
      end else begin
        secs = 0;
        if (digs.size() < 6) begin
          if (d >= "0" && d <= "9") digs.push_back(d);
          else begin pv = 5'b00001; in_cmd = 0; end
        end else begin
          in_cmd = 0;
          h = dv(digs[0]) * 10 + dv(digs[1]);
          m = dv(digs[2]) * 10 + dv(digs[3]);
          s = dv(digs[4]) * 10 + dv(digs[5]);
          if ((d == 8'h0D || d == 8'h0A) && h < 24 && m < 60 && s < 60) begin
            pv = 5'b00010; eh = h; em = m; es = s;
          end else pv = 5'b00001;
        end
      end
    end else if (t && in_cmd) begin
      secs++;
      if (secs >= TO) begin pv = 5'b00001; in_cmd = 0; digs.delete(); end
    end
    if (pv != '0) evq.push_back('{cyc, pv, eh, em, es});
    stq.push_back('{in_cmd, eh, em, es});
  endtask

  task automatic step(bit r, bit v, logic [7:0] d, bit t);
    rst          = r;
    bus.rx_valid = v;
    bus.rx_data  = v ? d : 8'($urandom);
    tick_1s      = t;
    @(posedge clk);
    cyc++;
    model(r, v, d, t);
    #1;
  endtask

  function automatic bit rtick();
    return ($urandom_range(0, 15) == 0);
  endfunction

  task automatic send(string str, bit gaps);
    for (int i = 0; i < str.len(); i++) begin
      step(0, 1, str[i], rtick());
      if (gaps) repeat ($urandom_range(0, 2)) step(0, 0, 8'h00, rtick());
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 8'h00, 0);
  endtask

  // monitor: per-cycle status plus pulses popped whenever the DUT shows one
  always @(negedge clk) begin
    st_t        st;
    ev_t        e;
    logic [4:0] act;
    if (stq.size() != 0) begin
      st = stq.pop_front();
      n_cmp++;
      if (bus.o_busy !== st.busy || int'(bus.o_set_hour) != st.h ||
          int'(bus.o_set_min) != st.m || int'(bus.o_set_sec) != st.s) begin
        n_bad++;
        $display("FAIL status cyc=%0d got busy=%b %0d:%0d:%0d exp busy=%b %0d:%0d:%0d", cyc,
                 bus.o_busy, bus.o_set_hour, bus.o_set_min, bus.o_set_sec, st.busy, st.h, st.m, st.s);
      end
      while (evq.size() != 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        n_bad++;
        $display("FAIL missed_pulse cyc=%0d got none exp pv=%b", e.cyc, e.pv);
      end
      act = {bus.o_run, bus.o_clear, bus.o_mode, bus.o_set_valid, bus.o_err};
      if (act !== 5'b0) begin
        n_cmp++;
        if (evq.size() != 0 && evq[0].cyc == cyc) begin
          e = evq.pop_front();
          if (act !== e.pv || (e.pv[1] && (int'(bus.o_set_hour) != e.h ||
              int'(bus.o_set_min) != e.m || int'(bus.o_set_sec) != e.s))) begin
            n_bad++;
            $display("FAIL pulse cyc=%0d got pv=%b %0d:%0d:%0d exp pv=%b %0d:%0d:%0d", cyc, act,
                     bus.o_set_hour, bus.o_set_min, bus.o_set_sec, e.pv, e.h, e.m, e.s);
          end
        end else begin
          n_bad++;
          $display("FAIL unexpected_pulse cyc=%0d got pv=%b exp none", cyc, act);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got no finish exp finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, h, m, s;
    string str;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) step(1, 0, 8'h00, 0);
    idle(2);

    send("RCM", 0);                       idle(3);
    send("S235959\r", 0);                 idle(3);
    send("S240000\n", 0);                 idle(3);
    send("S12", 0); idle(2); step(0, 0, 8'h00, 1); idle(1); step(0, 0, 8'h00, 1);
    idle(2); step(0, 0, 8'h00, 1);        idle(3);
    send("S12", 0); step(0, 0, 8'h00, 1); step(0, 0, 8'h00, 1);
    step(0, 1, "3", 1); send("456\r", 0); idle(3);
    send("S12a", 0); send("C", 0);        idle(3);
    send("r", 0);                         idle(2);
    send("S1234", 0); step(1, 0, 8'h00, 0); idle(3);
    send(" \r\nS000000\nS999999\r", 0);   idle(3);

    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 99);
      if (k < 30) begin
        str = " ";
        case ($urandom_range(0, 10))
          0: str = "R"; 1: str = "C"; 2: str = "M"; 3: str = "r"; 4: str = "c";
          5: str = "m"; 6: str = "x"; 7: str = "\r"; 8: str = "\n"; 9: str = "s";
          default: str = " ";
        endcase
        send(str, 1);
      end else if (k < 85) begin
        h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 23);
        m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 59);
        s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 59);
        str = $sformatf("S%02d%02d%02d%s", h, m, s, ($urandom_range(0, 1) != 0) ? "\r" : "\n");
        if ($urandom_range(0, 5) == 0) str.putc($urandom_range(1, 7), 8'($urandom_range(32, 126)));
        if ($urandom_range(0, 7) == 0) str = str.substr(0, $urandom_range(0, 6));
        send(str, $urandom_range(0, 1) != 0);
      end else if (k < 97) begin
        repeat ($urandom_range(1, 12)) step(0, 0, 8'h00, $urandom_range(0, 2) == 0);
      end else begin
        step(1, 0, 8'h00, 0);
      end
    end

    idle(5);
    n_cmp++;
    if (evq.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending exp 0", evq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
